// File: rtl/alarm_clock_pkg.sv
// Shared types and width helpers for the alarm buzzer/snooze controller.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_DONE    = 2'd3
    } alarm_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the longer of the two second-timer reload values.
    function automatic int timer_width(input int ring_s, input int snooze_s);
        return $clog2(max_int(ring_s, snooze_s) + 1);
    endfunction

    function automatic int count_width(input int max_snoozes);
        return (max_snoozes > 0) ? $clog2(max_snoozes + 1) : 1;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Cadenced square-wave tone: toggles every half-period during the on-phase,
// silent during the off-phase, phases alternate every CADENCE_CYCLES.
module buzzer_tone_gen #(
    parameter int CLK_IN         = 5000000,
    parameter int TONE_HZ        = 2000,
    parameter int CADENCE_CYCLES = 2500000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_Restart,
    output logic o_Buzzer
);

    localparam int HALF_PERIOD = CLK_IN / (2 * TONE_HZ);
    localparam int TONE_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int CAD_W       = (CADENCE_CYCLES > 1) ? $clog2(CADENCE_CYCLES) : 1;

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [CAD_W-1:0]  cad_cnt_q,  cad_cnt_d;
    logic              phase_on_q, phase_on_d;
    logic              buzzer_q,   buzzer_d;

    // Next-state for tone and cadence counters; a restart starts a fresh on-phase high.
    always_comb begin
        tone_cnt_d = '0;
        cad_cnt_d  = '0;
        phase_on_d = 1'b0;
        buzzer_d   = 1'b0;
        if (i_Enable) begin
            if (i_Restart) begin
                phase_on_d = 1'b1;
                buzzer_d   = 1'b1;
            end else if (cad_cnt_q == CAD_W'(CADENCE_CYCLES - 1)) begin
                phase_on_d = ~phase_on_q;
                buzzer_d   = ~phase_on_q;
            end else begin
                cad_cnt_d  = cad_cnt_q + CAD_W'(1);
                phase_on_d = phase_on_q;
                if (phase_on_q) begin
                    if (tone_cnt_q == TONE_W'(HALF_PERIOD - 1)) begin
                        buzzer_d = ~buzzer_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + TONE_W'(1);
                        buzzer_d   = buzzer_q;
                    end
                end
            end
        end
    end

    // Tone/cadence registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tone_cnt_q <= '0;
            cad_cnt_q  <= '0;
            phase_on_q <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            cad_cnt_q  <= cad_cnt_d;
            phase_on_q <= phase_on_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign o_Buzzer = buzzer_q;

endmodule

// File: rtl/alarm_buzzer_snooze.sv
// Alarm session controller: ring / snooze / dismiss / timeout with a snooze limit.
//   state   | meaning
//   IDLE    | waiting for an alarm match rising edge
//   RINGING | buzzer active, ring timeout running
//   SNOOZE  | ringing paused, snooze timer running
//   DONE    | session over, waiting for the match to end
module alarm_buzzer_snooze
    import alarm_clock_pkg::*;
#(
    parameter int CLK_IN         = 5000000,
    parameter int TONE_HZ        = 2000,
    parameter int CADENCE_CYCLES = 2500000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic                                i_Tick_1Hz,
    input  logic                                i_Alarm_Trigger,
    input  logic                                i_Alarm_Enable,
    input  logic                                i_Snooze,
    input  logic                                i_Dismiss,
    output logic                                o_Buzzer,
    output logic                                o_Ringing,
    output logic                                o_Snoozed,
    output logic [count_width(MAX_SNOOZES)-1:0] o_Snooze_Count
);

    localparam int TMR_W = timer_width(RING_TIMEOUT_S, SNOOZE_S);
    localparam int CNT_W = count_width(MAX_SNOOZES);

    alarm_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             trig_prev_q;
    logic             rise;
    logic             expire;
    logic             restart_tone;

    assign rise   = i_Alarm_Trigger & ~trig_prev_q;
    assign expire = i_Tick_1Hz && (timer_q == TMR_W'(1));

    // Next-state, timer and snooze-count logic; enable low overrides everything.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        count_d      = count_q;
        restart_tone = 1'b0;
        if (!i_Alarm_Enable) begin
            state_d = ST_IDLE;
            timer_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d      = ST_RINGING;
                        timer_d      = TMR_W'(RING_TIMEOUT_S);
                        count_d      = '0;
                        restart_tone = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (i_Dismiss) begin
                        state_d = ST_DONE;
                    end else if (i_Snooze && (count_q < CNT_W'(MAX_SNOOZES))) begin
                        state_d = ST_SNOOZE;
                        timer_d = TMR_W'(SNOOZE_S);
                        count_d = count_q + CNT_W'(1);
                    end else if (expire) begin
                        state_d = ST_DONE;
                        timer_d = '0;
                    end else if (i_Tick_1Hz && (timer_q != '0)) begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_SNOOZE: begin
                    if (i_Dismiss) begin
                        state_d = ST_DONE;
                    end else if (expire) begin
                        state_d      = ST_RINGING;
                        timer_d      = TMR_W'(RING_TIMEOUT_S);
                        restart_tone = 1'b1;
                    end else if (i_Tick_1Hz && (timer_q != '0)) begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!i_Alarm_Trigger) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, timer, count and trigger-history registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            trig_prev_q <= i_Alarm_Trigger;
        end
    end

    // Tone is registered against the next state so it rises together with o_Ringing.
    buzzer_tone_gen #(
        .CLK_IN         (CLK_IN),
        .TONE_HZ        (TONE_HZ),
        .CADENCE_CYCLES (CADENCE_CYCLES)
    ) u_tone (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Enable  (state_d == ST_RINGING),
        .i_Restart (restart_tone),
        .o_Buzzer  (o_Buzzer)
    );

    assign o_Ringing      = (state_q == ST_RINGING);
    assign o_Snoozed      = (state_q == ST_SNOOZE);
    assign o_Snooze_Count = count_q;

endmodule

// File: tb/tb_alarm_buzzer_snooze.sv
// Directed bench for alarm_buzzer_snooze with shrunk timing parameters.
module tb_alarm_buzzer_snooze;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       trig;
    logic       en;
    logic       snz;
    logic       dis;
    logic       buz;
    logic       ringing;
    logic       snoozed;
    logic [1:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    alarm_buzzer_snooze #(
        .CLK_IN         (1000),
        .TONE_HZ        (100),
        .CADENCE_CYCLES (50),
        .RING_TIMEOUT_S (5),
        .SNOOZE_S       (3),
        .MAX_SNOOZES    (2)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_Tick_1Hz      (tick),
        .i_Alarm_Trigger (trig),
        .i_Alarm_Enable  (en),
        .i_Snooze        (snz),
        .i_Dismiss       (dis),
        .o_Buzzer        (buz),
        .o_Ringing       (ringing),
        .o_Snoozed       (snoozed),
        .o_Snooze_Count  (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk_st(input string tag, input int r, input int s, input int c);
        chk({tag, "_ring"}, int'(ringing), r);
        chk({tag, "_snz"},  int'(snoozed), s);
        chk({tag, "_cnt"},  int'(cnt), c);
    endtask

    // Drop then raise the trigger to start a new session.
    task automatic retrigger();
        trig = 1'b0;
        step();
        trig = 1'b1;
        step();
    endtask

    initial begin
        int exp_b;
        rst = 1'b1; tick = 1'b0; trig = 1'b0; en = 1'b0; snz = 1'b0; dis = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_st("reset", 0, 0, 0);
        chk("reset_buz", int'(buz), 0);

        // Basic ring and cadence.
        en = 1'b1;
        trig = 1'b1;
        step();
        chk_st("ring_start", 1, 0, 0);
        chk("buz_k0", int'(buz), 1);
        for (int k = 1; k < 110; k++) begin
            step();
            exp_b = ((k % 100) < 50) ? (((k % 100) / 5) % 2 == 0 ? 1 : 0) : 0;
            chk($sformatf("buz_k%0d", k), int'(buz), exp_b);
        end

        // Timeout after exactly 5 ticks, no re-ring while match holds.
        for (int i = 0; i < 4; i++) tick_pulse();
        chk_st("to_4ticks", 1, 0, 0);
        tick_pulse();
        chk_st("to_5ticks", 0, 0, 0);
        chk("to_buz", int'(buz), 0);
        step();
        step();
        chk_st("to_hold", 0, 0, 0);
        retrigger();
        chk_st("to_rering", 1, 0, 0);
        chk("rering_buz", int'(buz), 1);

        // Snooze limit.
        snz = 1'b1; step(); snz = 1'b0;
        chk_st("snz1", 0, 1, 1);
        chk("snz1_buz", int'(buz), 0);
        tick_pulse();
        tick_pulse();
        chk_st("snz1_2t", 0, 1, 1);
        tick_pulse();
        chk_st("snz1_3t", 1, 0, 1);
        chk("snz1_buz_re", int'(buz), 1);
        snz = 1'b1; step(); snz = 1'b0;
        chk_st("snz2", 0, 1, 2);
        for (int i = 0; i < 3; i++) tick_pulse();
        chk_st("snz2_3t", 1, 0, 2);
        snz = 1'b1; step(); snz = 1'b0;
        chk_st("snz3_ign", 1, 0, 2);
        dis = 1'b1; step(); dis = 1'b0;
        chk_st("dismiss", 0, 0, 2);
        retrigger();
        chk_st("new_sess", 1, 0, 0);

        // Dismiss beats snooze.
        dis = 1'b1; snz = 1'b1; step(); dis = 1'b0; snz = 1'b0;
        chk_st("dis_snz", 0, 0, 0);
        retrigger();
        chk_st("ring_b", 1, 0, 0);

        // Tick coincident with snooze entry is ignored.
        snz = 1'b1; tick = 1'b1; step(); snz = 1'b0; tick = 1'b0;
        chk_st("snz_tick", 0, 1, 1);
        tick_pulse();
        tick_pulse();
        chk_st("snz_tick_2t", 0, 1, 1);
        tick_pulse();
        chk_st("snz_tick_3t", 1, 0, 1);

        // Enable drop during snooze.
        snz = 1'b1; step(); snz = 1'b0;
        chk_st("snz_b", 0, 1, 2);
        en = 1'b0; step();
        chk_st("en_drop", 0, 0, 0);
        chk("en_drop_buz", int'(buz), 0);
        en = 1'b1; step();
        chk_st("en_back_norise", 0, 0, 0);
        retrigger();
        chk_st("ring_c", 1, 0, 0);

        // Reset mid-ring with trigger held high.
        step();
        rst = 1'b1; step();
        chk_st("rst_mid", 0, 0, 0);
        chk("rst_mid_buz", int'(buz), 0);
        rst = 1'b0; step();
        chk_st("rst_release", 1, 0, 0);
        chk("rst_release_buz", int'(buz), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_buzzer_snooze.md
Name: alarm_buzzer_snooze

Overview:
- Downstream consumer of the alarm-on signal produced by the alarm clock top level.
- Turns the alarm match into a ringing session with a snooze button, a dismiss button, auto-timeout and a snooze limit.
- Drives a cadenced square-wave tone on the buzzer pin.
- Runs on the 5 MHz system clock and uses the existing 1 Hz pulse and the debounced button pulses.

Parameters:
- CLK_IN, 5000000: input clock frequency in Hz.
- TONE_HZ, 2000: buzzer tone frequency in Hz. Tone half-period = CLK_IN/(2*TONE_HZ) cycles.
- CADENCE_CYCLES, 2500000: length of the beep-on phase and of the beep-off phase, in cycles.
- RING_TIMEOUT_S, 60: seconds of ringing before automatic stop.
- SNOOZE_S, 300: snooze duration in seconds.
- MAX_SNOOZES, 3: number of snoozes allowed per session.

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tick_1Hz  input  1  single-cycle pulse, once per second.
- i_Alarm_Trigger  input  1  level, high while alarm time equals current time.
- i_Alarm_Enable  input  1  level, alarm armed.
- i_Snooze  input  1  single-cycle pulse from a debounced button.
- i_Dismiss  input  1  single-cycle pulse from a debounced button.
- o_Buzzer  output  1  gated tone.
- o_Ringing  output  1  high in RINGING.
- o_Snoozed  output  1  high in SNOOZE.
- o_Snooze_Count  output  $clog2(MAX_SNOOZES+1)  snoozes used this session.

Behaviour:
- Clock and reset: one clock, i_Clk. i_Reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; timer 0; trigger history register 0; tone and cadence counters 0.
- States:
  - IDLE: waiting for an alarm.
  - RINGING: buzzer active.
  - SNOOZE: ringing paused for the snooze interval.
  - DONE: session over; waits for the alarm match to end.
- Trigger detection: rise = i_Alarm_Trigger & ~prev. prev is registered every cycle.
- Cycle-level latency: the state changes on the edge where the qualifying input is sampled. o_Ringing and o_Snoozed are decoded directly from the state register, so they are valid one cycle after the stimulus.
- Transitions, with per-cycle priority i_Alarm_Enable low > i_Dismiss > i_Snooze > timer expiry:
  - IDLE to RINGING: rise and i_Alarm_Enable. Timer loads RING_TIMEOUT_S; count clears to 0.
  - RINGING to DONE: i_Dismiss.
  - RINGING to SNOOZE: i_Snooze with count < MAX_SNOOZES. Timer loads SNOOZE_S; count increments.
  - RINGING, i_Snooze with count == MAX_SNOOZES: ignored; stays in RINGING.
  - RINGING to DONE: timer expiry.
  - SNOOZE to RINGING: timer expiry. Timer reloads RING_TIMEOUT_S; count is kept.
  - SNOOZE to DONE: i_Dismiss.
  - DONE to IDLE: i_Alarm_Trigger low.
  - Any state to IDLE: i_Alarm_Enable low. Count clears.
- Timer:
  - Decrements on i_Tick_1Hz in RINGING and SNOOZE.
  - Expiry = i_Tick_1Hz while timer == 1, giving exactly N ticks.
  - A tick in the cycle the timer loads is ignored.
  - Timer width is $clog2(max(RING_TIMEOUT_S, SNOOZE_S)+1).
- Counter saturation: o_Snooze_Count saturates at MAX_SNOOZES.
- Tone and cadence:
  - Tone and cadence counters clear on every entry to RINGING.
  - In the cycle after entry, o_Buzzer = 1 and the on-phase begins.
  - During the on-phase, o_Buzzer toggles every half-period.
  - During the off-phase, o_Buzzer = 0.
  - Phases alternate every CADENCE_CYCLES.
  - Outside RINGING, o_Buzzer = 0 and the counters are held at 0.
  - o_Buzzer is registered.
- Trigger re-assertion: DONE never re-rings within the same match, because a new rise is required after returning to IDLE. Re-asserting i_Alarm_Trigger during SNOOZE has no effect.
- Reset mid-session: returns to IDLE on the next edge. A trigger that is still high at release produces a rise and starts ringing, consistent with the rule above.

Decomposition:
- Package alarm_clock_pkg holds:
  - the state enum (IDLE=0, RINGING=1, SNOOZE=2, DONE=3);
  - helper constants for the timer and count widths.
- Sub-module buzzer_tone_gen holds the tone and cadence counters. Its inputs are i_Clk, i_Reset, i_Enable, i_Restart; its output is o_Buzzer. It is parameterised by CLK_IN, TONE_HZ and CADENCE_CYCLES.
- The FSM and the timer stay in the top of this block.

Test Plan:
- Bench parameters: CLK_IN=1000, TONE_HZ=100 (half-period 5), CADENCE_CYCLES=50, RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZES=2.
- Basic ring: enable=1, trigger 0 to 1 → o_Ringing=1 the next cycle. o_Buzzer toggles every 5 cycles for 50 cycles, then stays 0 for 50 cycles.
- Timeout: ringing, 5 ticks → DONE on the 5th tick. Trigger still high → no re-ring. Trigger 0 then 1 → rings again.
- Snooze limit: snooze, 3 ticks, ring, snooze, 3 ticks, ring (count=2). A third snooze is ignored: o_Ringing stays 1 and o_Snooze_Count=2.
- Dismiss beats snooze: i_Dismiss and i_Snooze in the same cycle → DONE, count unchanged. Tick coincident with snooze entry → still 3 further ticks required.
- Enable drop: i_Alarm_Enable=0 during SNOOZE → IDLE the next cycle, o_Buzzer=0, count=0.
- Reset mid-ring: i_Reset pulse during RINGING → all outputs 0 the next cycle. Trigger held high at release → ringing restarts one cycle after release.
